// File: rtl/inv_subbytes_pkg.sv
// Shared types and constants for the sequential inverse SubBytes engine.
// Optional block counter is enabled with INV_SUBBYTES_SEQ_BLKCNT_EN (see inv_subbytes_seq).
package inv_subbytes_pkg;

    localparam int AES_BYTES   = 16;
    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } invsb_state_t;

endpackage

// File: rtl/inv_sbox_unit.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_sbox_unit (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row r holds the results for inputs 0xr0..0xrF.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_subbytes_seq.sv
// Time-multiplexed inverse SubBytes: LANES shared S-boxes walk the 16 bytes in 16/LANES cycles.
// Define INV_SUBBYTES_SEQ_BLKCNT_EN to add the blk_count transfer counter output.
module inv_subbytes_seq
    import inv_subbytes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
`ifdef INV_SUBBYTES_SEQ_BLKCNT_EN
    ,
    output logic [15:0]            blk_count
`endif
);

    // LANES must divide 16 (1, 2, 4, 8 or 16).
    localparam int GROUPS = AES_BYTES / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    invsb_state_t           r_state, w_stateNext;
    logic [CNT_W-1:0]       r_cnt, w_cntNext;
    logic [AES_BLOCK_W-1:0] r_data, w_dataNext, w_subbed;
    logic                   r_inReady, r_outValid, r_busy;
    logic                   w_accept;
    logic [7:0]             w_curBytes [AES_BYTES];
    logic [7:0]             w_subBytes [AES_BYTES];
    logic [3:0]             w_laneIdx  [LANES];
    logic [7:0]             w_laneIn   [LANES];
    logic [7:0]             w_laneOut  [LANES];

    for (genvar b = 0; b < AES_BYTES; b++) begin : g_bytes
        assign w_curBytes[b]       = r_data[8*b +: 8];
        assign w_subbed[8*b +: 8]  = w_subBytes[b];
    end

    // Lane j always serves byte cnt*LANES+j of the current group.
    for (genvar j = 0; j < LANES; j++) begin : g_lanes
        assign w_laneIdx[j] = 4'(int'(r_cnt) * LANES + j);
        assign w_laneIn[j]  = w_curBytes[w_laneIdx[j]];

        inv_sbox_unit u_sbox (
            .i_byte (w_laneIn[j]),
            .o_byte (w_laneOut[j])
        );
    end

    always_comb begin
        w_subBytes = w_curBytes;
        for (int j = 0; j < LANES; j++) begin
            w_subBytes[w_laneIdx[j]] = w_laneOut[j];
        end
    end

    assign w_accept = in_valid && r_inReady;

    // clear overrides every transition but leaves the data register alone.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_dataNext  = r_data;
        if (clear) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_dataNext  = in_data;
                        w_cntNext   = '0;
                        w_stateNext = SUB;
                    end
                end
                SUB: begin
                    w_dataNext = w_subbed;
                    if (r_cnt == LAST_GRP) begin
                        w_cntNext   = '0;
                        w_stateNext = DONE;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_stateNext = IDLE;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_data     <= w_dataNext;
            r_inReady  <= (w_stateNext == IDLE);
            r_outValid <= (w_stateNext == DONE);
            r_busy     <= (w_stateNext != IDLE);
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_data;
    assign busy      = r_busy;

`ifdef INV_SUBBYTES_SEQ_BLKCNT_EN
    logic [15:0] r_blkCount;

    // Counts completed output handshakes; survives clear, wraps naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_blkCount <= '0;
        end else if (r_outValid && out_ready) begin
            r_blkCount <= r_blkCount + 16'd1;
        end
    end

    assign blk_count = r_blkCount;
`endif

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed bench for inv_subbytes_seq with LANES=4, 1 and 16 instances side by side.
// Covers blk_count only when INV_SUBBYTES_SEQ_BLKCNT_EN is defined.
module tb_inv_subbytes_seq;

    localparam int NDUT = 3;
    localparam int EXP_LAT [NDUT] = '{4, 16, 1};

    logic         clk = 1'b0;
    logic         nRst;
    logic         clearIn   [NDUT];
    logic         inValid   [NDUT];
    logic         inReady   [NDUT];
    logic [127:0] inData    [NDUT];
    logic         outValid  [NDUT];
    logic         outReady  [NDUT];
    logic [127:0] outData   [NDUT];
    logic         busy      [NDUT];
    logic [15:0]  blkCount  [NDUT];

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int LN = (k == 0) ? 4 : ((k == 1) ? 1 : 16);
        inv_subbytes_seq #(.LANES(LN)) u_dut (
            .clk       (clk),
            .n_rst     (nRst),
            .clear     (clearIn[k]),
            .in_valid  (inValid[k]),
            .in_ready  (inReady[k]),
            .in_data   (inData[k]),
            .out_valid (outValid[k]),
            .out_ready (outReady[k]),
            .out_data  (outData[k]),
            .busy      (busy[k])
`ifdef INV_SUBBYTES_SEQ_BLKCNT_EN
            ,
            .blk_count (blkCount[k])
`endif
        );
`ifndef INV_SUBBYTES_SEQ_BLKCNT_EN
        assign blkCount[k] = 16'h0;
`endif
    end

    // Forward S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sboxFwd(input logic [7:0] v);
        logic [7:0] r = 8'h00;
        if (v != 8'h00) begin
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gmul(r, v);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic sendState(input int k, input logic [127:0] data,
                             output logic [127:0] got, output int lat, output bit timedOut);
        int budget;
        timedOut = 1'b0;
        lat = 0;
        got = '0;
        @(negedge clk);
        outReady[k] = 1'b1;
        inData[k]   = data;
        inValid[k]  = 1'b1;
        budget = 0;
        while (inReady[k] !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (inReady[k] !== 1'b1) begin
            inValid[k] = 1'b0;
            timedOut = 1'b1;
            return;
        end
        @(negedge clk);
        inValid[k] = 1'b0;
        while (outValid[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (outValid[k] !== 1'b1) begin
            timedOut = 1'b1;
            return;
        end
        got = outData[k];
        @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            clearIn[k] = 1'b0; inValid[k] = 1'b0; outReady[k] = 1'b0; inData[k] = '0;
        end
        #3;
        testsRun++;
        if ({inReady[0], outValid[0], busy[0]} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000", {inReady[0], outValid[0], busy[0]});
        end
        testsRun++;
        if (outData[0] !== 128'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h expected 0", outData[0]);
        end
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        testsRun++;
        if (inReady[0] !== 1'b1 || busy[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle: in_ready=%b busy=%b expected 1/0", inReady[0], busy[0]);
        end
    endtask

    task automatic test_vectors();
        logic [127:0] got;
        int lat;
        bit to;
        sendState(0, {16{8'h63}}, got, lat, to);
        testsRun++;
        if (to || got !== 128'h0) begin
            testsFailed++;
            $display("[TB] FAIL all63_data: got %h timeout=%0d expected 0", got, to);
        end
        testsRun++;
        if (lat !== 4) begin
            testsFailed++;
            $display("[TB] FAIL all63_latency: got %0d expected 4", lat);
        end
        sendState(0, 128'h0F0E0D0C0B0A09080706050403020100, got, lat, to);
        testsRun++;
        if (got[7:0] !== 8'h52 || got[15:8] !== 8'h09 || got[23:16] !== 8'h6A || got[127:120] !== 8'hFB) begin
            testsFailed++;
            $display("[TB] FAIL ramp_bytes: got b0=%h b1=%h b2=%h b15=%h expected 52 09 6a fb",
                     got[7:0], got[15:8], got[23:16], got[127:120]);
        end
        testsRun++;
        if (to || got !== 128'hFBD7F3819EA340BF38A53630D56A0952) begin
            testsFailed++;
            $display("[TB] FAIL ramp_full: got %h expected fbd7f3819ea340bf38a53630d56a0952", got);
        end
        sendState(0, 128'h76ABD7FE2B670130C56F6BF27B777C63, got, lat, to);
        testsRun++;
        if (to || got !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            testsFailed++;
            $display("[TB] FAIL sbox_row: got %h expected 0f0e0d0c0b0a09080706050403020100", got);
        end
        sendState(0, {16{8'hFF}}, got, lat, to);
        testsRun++;
        if (to || got !== {16{8'h7D}}) begin
            testsFailed++;
            $display("[TB] FAIL allff: got %h expected all 7d", got);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] expA = {16{8'h00}};
        logic [127:0] expB = 128'h0F0E0D0C0B0A09080706050403020100;
        int budget;
        @(negedge clk);
        outReady[0] = 1'b0;
        inData[0]   = {16{8'h63}};
        inValid[0]  = 1'b1;
        budget = 0;
        while (inReady[0] !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
        @(negedge clk);
        inValid[0] = 1'b0;
        budget = 0;
        while (outValid[0] !== 1'b1 && budget < 40) begin @(negedge clk); budget++; end
        testsRun++;
        if (outValid[0] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_reach_done: out_valid=%b expected 1", outValid[0]);
        end
        inData[0]  = 128'h76ABD7FE2B670130C56F6BF27B777C63;
        inValid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            testsRun++;
            if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0 || outData[0] !== expA) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h expected 1 0 %h",
                         c, outValid[0], inReady[0], outData[0], expA);
            end
        end
        outReady[0] = 1'b1;
        @(negedge clk);
        testsRun++;
        if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || busy[0] !== 1'b0 || outData[0] !== expA) begin
            testsFailed++;
            $display("[TB] FAIL bp_release: valid=%b ready=%b busy=%b data=%h expected 0 1 0 %h",
                     outValid[0], inReady[0], busy[0], outData[0], expA);
        end
        @(negedge clk);
        inValid[0] = 1'b0;
        testsRun++;
        if (busy[0] !== 1'b1 || inReady[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_second_accept: busy=%b ready=%b expected 1 0", busy[0], inReady[0]);
        end
        budget = 0;
        while (outValid[0] !== 1'b1 && budget < 40) begin @(negedge clk); budget++; end
        testsRun++;
        if (outValid[0] !== 1'b1 || outData[0] !== expB) begin
            testsFailed++;
            $display("[TB] FAIL bp_second_data: valid=%b data=%h expected 1 %h", outValid[0], outData[0], expB);
        end
        @(negedge clk);
    endtask

    task automatic test_clear();
        logic [127:0] got;
        int lat;
        bit to;
        bit sawValid;
        int budget;
        @(negedge clk);
        outReady[0] = 1'b1;
        inData[0]   = {16{8'h63}};
        inValid[0]  = 1'b1;
        budget = 0;
        while (inReady[0] !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
        @(negedge clk);
        inValid[0] = 1'b0;
        @(negedge clk);
        clearIn[0] = 1'b1;
        @(negedge clk);
        clearIn[0] = 1'b0;
        testsRun++;
        if (busy[0] !== 1'b0 || inReady[0] !== 1'b1 || outValid[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear_to_idle: busy=%b ready=%b valid=%b expected 0 1 0",
                     busy[0], inReady[0], outValid[0]);
        end
        sawValid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (outValid[0] === 1'b1) sawValid = 1'b1;
        end
        testsRun++;
        if (sawValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear_no_valid: out_valid seen=%b expected 0", sawValid);
        end
        clearIn[0] = 1'b1;
        inValid[0] = 1'b1;
        @(negedge clk);
        clearIn[0] = 1'b0;
        inValid[0] = 1'b0;
        testsRun++;
        if (busy[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear_blocks_accept: busy=%b expected 0", busy[0]);
        end
        sendState(0, 128'h0F0E0D0C0B0A09080706050403020100, got, lat, to);
        testsRun++;
        if (to || got !== 128'hFBD7F3819EA340BF38A53630D56A0952 || lat !== 4) begin
            testsFailed++;
            $display("[TB] FAIL clear_recover: got %h lat %0d expected fbd7f3819ea340bf38a53630d56a0952 lat 4",
                     got, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int lat;
        bit to;
        int budget;
        @(negedge clk);
        outReady[0] = 1'b1;
        inData[0]   = 128'h0F0E0D0C0B0A09080706050403020100;
        inValid[0]  = 1'b1;
        budget = 0;
        while (inReady[0] !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
        @(negedge clk);
        inValid[0] = 1'b0;
        @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        testsRun++;
        if ({inReady[0], outValid[0], busy[0]} !== 3'b000 || outData[0] !== 128'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid: ctrl=%b data=%h expected 000 0",
                     {inReady[0], outValid[0], busy[0]}, outData[0]);
        end
        @(negedge clk);
        nRst = 1'b1;
        sendState(0, 128'h76ABD7FE2B670130C56F6BF27B777C63, got, lat, to);
        testsRun++;
        if (to || got !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            testsFailed++;
            $display("[TB] FAIL reset_recover: got %h expected 0f0e0d0c0b0a09080706050403020100", got);
        end
    endtask

    task automatic test_lanes();
        logic [127:0] got, x, stim;
        int lat;
        bit to;
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 2; n++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                for (int b = 0; b < 16; b++) stim[8*b +: 8] = sboxFwd(x[8*b +: 8]);
                sendState(k, stim, got, lat, to);
                testsRun++;
                if (to || got !== x) begin
                    testsFailed++;
                    $display("[TB] FAIL lanes_data dut%0d: got %h expected %h", k, got, x);
                end
                testsRun++;
                if (lat !== EXP_LAT[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL lanes_latency dut%0d: got %0d expected %0d", k, lat, EXP_LAT[k]);
                end
            end
        end
        sendState(2, 128'h0F0E0D0C0B0A09080706050403020100, got, lat, to);
        testsRun++;
        if (to || got !== 128'hFBD7F3819EA340BF38A53630D56A0952) begin
            testsFailed++;
            $display("[TB] FAIL lanes16_ramp: got %h expected fbd7f3819ea340bf38a53630d56a0952", got);
        end
        sendState(1, 128'h0F0E0D0C0B0A09080706050403020100, got, lat, to);
        testsRun++;
        if (to || got !== 128'hFBD7F3819EA340BF38A53630D56A0952) begin
            testsFailed++;
            $display("[TB] FAIL lanes1_ramp: got %h expected fbd7f3819ea340bf38a53630d56a0952", got);
        end
    endtask

`ifdef INV_SUBBYTES_SEQ_BLKCNT_EN
    task automatic test_blk_count();
        logic [127:0] got;
        int lat;
        bit to;
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        for (int n = 0; n < 3; n++) sendState(0, {16{8'h63}}, got, lat, to);
        clearIn[0] = 1'b1;
        @(negedge clk);
        clearIn[0] = 1'b0;
        testsRun++;
        if (blkCount[0] !== 16'd3) begin
            testsFailed++;
            $display("[TB] FAIL blk_count: got %0d expected 3", blkCount[0]);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_lanes();
`ifdef INV_SUBBYTES_SEQ_BLKCNT_EN
        test_blk_count();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
